// File: rtl/counter_arbiter.sv
// counter_arbiter: free-running round-robin master index for the AXI-Lite
// interconnect arbiter. number_o advances 0..NUM_MASTERS-1 on every rising
// edge of tick_count_i and wraps; resetn_i is a synchronous active-low reset.
// Optional build macro COUNTER_ARBITER_ONEHOT_EN adds a registered one-hot
// grant vector (grant_onehot_o) that always equals 1 << number_o.
module counter_arbiter #(
  parameter int NUM_MASTERS = 4
) (
  input  logic                           tick_count_i,
  input  logic                           resetn_i,
  output logic [$clog2(NUM_MASTERS)-1:0] number_o
`ifdef COUNTER_ARBITER_ONEHOT_EN
  ,
  output logic [NUM_MASTERS-1:0]         grant_onehot_o
`endif
);

  localparam int W = $clog2(NUM_MASTERS);
  localparam logic [W-1:0] LAST = W'(NUM_MASTERS - 1);

  // A single master has nothing to arbitrate and gives a zero-width index.
  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 256) begin : g_bad_num_masters
      $error("counter_arbiter: NUM_MASTERS=%0d outside legal range 2..256", NUM_MASTERS);
    end
  endgenerate

  logic [W-1:0] number_d;
  logic [W-1:0] number_q;

  // Next index: increment below the last master, otherwise return to 0.
  // Written as "below LAST" so that any out-of-range or unknown state also
  // falls into the return-to-zero branch on the next edge.
  always_comb begin
    number_d = '0;
    if (number_q < LAST) begin
      number_d = number_q + W'(1);
    end
  end

  // Index register; reset has priority over counting.
  always_ff @(posedge tick_count_i) begin
    if (!resetn_i) begin
      number_q <= '0;
    end else begin
      number_q <= number_d;
    end
  end

  assign number_o = number_q;

`ifdef COUNTER_ARBITER_ONEHOT_EN
  logic [NUM_MASTERS-1:0] grant_d;
  logic [NUM_MASTERS-1:0] grant_q;

  // Decode the next index so the grant vector moves on the same edge as number_o.
  always_comb begin
    grant_d = NUM_MASTERS'(1) << number_d;
  end

  // Grant register; reset selects master 0.
  always_ff @(posedge tick_count_i) begin
    if (!resetn_i) begin
      grant_q <= NUM_MASTERS'(1);
    end else begin
      grant_q <= grant_d;
    end
  end

  assign grant_onehot_o = grant_q;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: self-checking bench for counter_arbiter. Four instances
// (NUM_MASTERS = 4, 3, 5, 2) share one clock and reset. Each driven edge pushes
// the expected indices into a scoreboard queue; the values are popped and
// compared 1 ns after the edge. Define COUNTER_ARBITER_ONEHOT_EN to also
// check grant_onehot_o on the NUM_MASTERS=4 instance.
`timescale 1ns/1ps
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] num4;
  logic [1:0] num3;
  logic [2:0] num5;
  logic [0:0] num2;
`ifdef COUNTER_ARBITER_ONEHOT_EN
  logic [3:0] oh4;
  logic [2:0] oh3;
  logic [4:0] oh5;
  logic [1:0] oh2;
`endif

  typedef struct {
    int         n4;
    int         n3;
    int         n5;
    int         n2;
    logic [3:0] oh4;
  } exp_t;

  exp_t sb[$];
  int   m4 = 0, m3 = 0, m5 = 0, m2 = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  counter_arbiter #(.NUM_MASTERS(4)) u4 (
    .tick_count_i(clk), .resetn_i(resetn), .number_o(num4)
`ifdef COUNTER_ARBITER_ONEHOT_EN
    , .grant_onehot_o(oh4)
`endif
  );
  counter_arbiter #(.NUM_MASTERS(3)) u3 (
    .tick_count_i(clk), .resetn_i(resetn), .number_o(num3)
`ifdef COUNTER_ARBITER_ONEHOT_EN
    , .grant_onehot_o(oh3)
`endif
  );
  counter_arbiter #(.NUM_MASTERS(5)) u5 (
    .tick_count_i(clk), .resetn_i(resetn), .number_o(num5)
`ifdef COUNTER_ARBITER_ONEHOT_EN
    , .grant_onehot_o(oh5)
`endif
  );
  counter_arbiter #(.NUM_MASTERS(2)) u2 (
    .tick_count_i(clk), .resetn_i(resetn), .number_o(num2)
`ifdef COUNTER_ARBITER_ONEHOT_EN
    , .grant_onehot_o(oh2)
`endif
  );

  // Drive resetn for the coming edge, push the expected result, then advance
  // to 1 ns after that edge.
  task automatic drive_edge(input logic rstn);
    exp_t e;
    resetn = rstn;
    if (!rstn) begin
      m4 = 0; m3 = 0; m5 = 0; m2 = 0;
    end else begin
      m4 = (m4 + 1) % 4;
      m3 = (m3 + 1) % 3;
      m5 = (m5 + 1) % 5;
      m2 = (m2 + 1) % 2;
    end
    e.n4 = m4; e.n3 = m3; e.n5 = m5; e.n2 = m2;
    e.oh4 = 4'b0001 << m4;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive_edge(1'b0);
      e = sb.pop_front();
      n_tests++;
      if ({30'd0, num4} !== e.n4 || {30'd0, num3} !== e.n3 ||
          {29'd0, num5} !== e.n5 || {31'd0, num2} !== e.n2) begin
        n_fail++;
        $display("FAIL reset[%0d]: got n4=%0d n3=%0d n5=%0d n2=%0d, expected all 0",
                 i, num4, num3, num5, num2);
      end
`ifdef COUNTER_ARBITER_ONEHOT_EN
      n_tests++;
      if (oh4 !== 4'b0001) begin
        n_fail++;
        $display("FAIL reset onehot: got %b expected 0001", oh4);
      end
`endif
    end
  endtask

  task automatic test_count_wrap(input int edges);
    exp_t e;
    for (int i = 0; i < edges; i++) begin
      drive_edge(1'b1);
      e = sb.pop_front();
      n_tests++;
      if ({30'd0, num4} !== e.n4) begin
        n_fail++;
        $display("FAIL count n4 edge %0d: got %0d expected %0d", i, num4, e.n4);
      end
      n_tests++;
      if ({30'd0, num3} !== e.n3 || num3 === 2'd3) begin
        n_fail++;
        $display("FAIL count n3 edge %0d: got %0d expected %0d", i, num3, e.n3);
      end
      n_tests++;
      if ({29'd0, num5} !== e.n5 || num5 > 3'd4) begin
        n_fail++;
        $display("FAIL count n5 edge %0d: got %0d expected %0d", i, num5, e.n5);
      end
      n_tests++;
      if ({31'd0, num2} !== e.n2) begin
        n_fail++;
        $display("FAIL count n2 edge %0d: got %0d expected %0d", i, num2, e.n2);
      end
`ifdef COUNTER_ARBITER_ONEHOT_EN
      n_tests++;
      if (oh4 !== e.oh4 || oh4 !== (4'b0001 << num4)) begin
        n_fail++;
        $display("FAIL onehot edge %0d: got %b expected %b", i, oh4, e.oh4);
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   guard;
    // Count until the NUM_MASTERS=4 instance sits at 2 (bounded).
    guard = 0;
    while (m4 != 2 && guard < 8) begin
      drive_edge(1'b1);
      e = sb.pop_front();
      guard++;
      n_tests++;
      if ({30'd0, num4} !== e.n4) begin
        n_fail++;
        $display("FAIL pre-reset n4: got %0d expected %0d", num4, e.n4);
      end
    end
    // One reset edge while counting.
    drive_edge(1'b0);
    e = sb.pop_front();
    n_tests++;
    if ({30'd0, num4} !== e.n4 || {29'd0, num5} !== e.n5) begin
      n_fail++;
      $display("FAIL mid reset: got n4=%0d n5=%0d expected 0 0", num4, num5);
    end
    // Resume: 0 -> 1.
    drive_edge(1'b1);
    e = sb.pop_front();
    n_tests++;
    if ({30'd0, num4} !== e.n4 || {31'd0, num2} !== e.n2) begin
      n_fail++;
      $display("FAIL resume: got n4=%0d n2=%0d expected %0d %0d", num4, num2, e.n4, e.n2);
    end
    // Pulse resetn low between edges: no effect until an edge samples it.
    resetn = 1'b0;
    #2;
    n_tests++;
    if (num4 !== 2'd1 || num3 !== 2'd1) begin
      n_fail++;
      $display("FAIL async glitch: got n4=%0d n3=%0d expected 1 1", num4, num3);
    end
    resetn = 1'b1;
    drive_edge(1'b1);
    e = sb.pop_front();
    n_tests++;
    if ({30'd0, num4} !== e.n4 || {30'd0, num3} !== e.n3) begin
      n_fail++;
      $display("FAIL after glitch: got n4=%0d n3=%0d expected %0d %0d", num4, num3, e.n4, e.n3);
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap(30);
    test_mid_reset();
    test_count_wrap(8);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
